// File: rtl/apb_regbank.sv
// APB3 register-bank slave: RW output registers, synchronised RO inputs,
// sticky change flags with an interrupt mask, programmable wait states and PSLVERR.
module apb_regbank #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 5,
    parameter int N_OUT       = 2,
    parameter int N_IN        = 2,
    parameter int WAIT_STATES = 0,
    parameter logic [DATA_W-1:0] ID_VALUE = 8'hB8
) (
    input  logic                     PCLK,
    input  logic                     PRESET,
    input  logic                     PSEL,
    input  logic [ADDR_W-1:0]        PADDR,
    input  logic                     PENABLE,
    input  logic                     PWRITE,
    input  logic [DATA_W-1:0]        PWDATA,
    output logic [DATA_W-1:0]        PRDATA,
    output logic                     PREADY,
    output logic                     PSLVERR,
    input  logic [N_IN*DATA_W-1:0]   IN_BUS,
    output logic [N_OUT*DATA_W-1:0]  OUT_BUS,
    output logic                     CHG_IRQ
);

    localparam logic [31:0] A_MASK = 32'd29;
    localparam logic [31:0] A_CHG  = 32'd30;
    localparam logic [31:0] A_ID   = 32'd31;
    localparam logic [2:0]  WS     = 3'(WAIT_STATES);

    if ((N_OUT + N_IN) > 29) begin : g_bad_map
        $error("apb_regbank: N_OUT + N_IN must not exceed 29");
    end

    // Bus phase is decoded from PSEL/PENABLE each cycle; the wait counter is the only state.
    typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_ACCESS} phase_t;

    phase_t                   w_phase;
    logic [2:0]               r_wait_cnt;
    logic [2:0]               w_wait_cnt_next;
    logic                     w_ready;
    logic                     w_err;
    logic                     w_wr;
    logic [31:0]              w_addr;
    logic [DATA_W-1:0]        w_rdata;
    logic [N_IN*DATA_W-1:0]   w_in_sync;
    logic [N_IN-1:0]          w_chg;
    logic [N_IN-1:0]          r_mask;
    logic                     r_det_en;
    logic                     r_irq;

    always_comb begin
        w_phase = PH_IDLE;
        if (PSEL) begin
            w_phase = PENABLE ? PH_ACCESS : PH_SETUP;
        end
        w_ready = !PRESET && (w_phase == PH_ACCESS) && (r_wait_cnt == WS);
        w_wait_cnt_next = '0;
        if ((w_phase == PH_ACCESS) && !w_ready) begin
            w_wait_cnt_next = r_wait_cnt + 3'd1;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= w_wait_cnt_next;
        end
    end

    assign w_addr = 32'(PADDR);

    always_comb begin
        w_rdata = '0;
        w_err   = 1'b0;
        if (w_addr < 32'(N_OUT)) begin
            for (int k = 0; k < N_OUT; k++) begin
                if (w_addr == 32'(k)) w_rdata = OUT_BUS[k*DATA_W +: DATA_W];
            end
        end else if (w_addr < 32'(N_OUT + N_IN)) begin
            for (int k = 0; k < N_IN; k++) begin
                if (w_addr == 32'(N_OUT + k)) w_rdata = w_in_sync[k*DATA_W +: DATA_W];
            end
            w_err = PWRITE;
        end else if (w_addr == A_MASK) begin
            w_rdata = DATA_W'(r_mask);
        end else if (w_addr == A_CHG) begin
            w_rdata = DATA_W'(w_chg);
        end else if (w_addr == A_ID) begin
            w_rdata = ID_VALUE;
            w_err   = PWRITE;
        end else begin
            w_err = 1'b1;
        end
    end

    assign PREADY  = w_ready;
    assign PSLVERR = w_ready & w_err;
    assign PRDATA  = (w_ready && !PWRITE && !w_err) ? w_rdata : '0;
    assign w_wr    = w_ready & PWRITE & ~w_err;

    genvar gi;
    for (gi = 0; gi < N_OUT; gi++) begin : g_out
        logic [DATA_W-1:0] r_out;
        always_ff @(posedge PCLK) begin
            if (PRESET) begin
                r_out <= '0;
            end else if (w_wr && (w_addr == 32'(gi))) begin
                r_out <= PWDATA;
            end
        end
        assign OUT_BUS[gi*DATA_W +: DATA_W] = r_out;
    end

    for (gi = 0; gi < N_IN; gi++) begin : g_in
        logic [DATA_W-1:0] r_sync1;
        logic [DATA_W-1:0] r_sync2;
        logic [DATA_W-1:0] r_prev;
        logic              r_chg;
        always_ff @(posedge PCLK) begin
            if (PRESET) begin
                r_sync1 <= '0;
                r_sync2 <= '0;
                r_prev  <= '0;
                r_chg   <= 1'b0;
            end else begin
                r_sync1 <= IN_BUS[gi*DATA_W +: DATA_W];
                r_sync2 <= r_sync1;
                r_prev  <= r_sync2;
                // A fresh change event outranks a simultaneous W1C clear.
                if (r_det_en && (r_sync2 != r_prev)) begin
                    r_chg <= 1'b1;
                end else if (w_wr && (w_addr == A_CHG) && PWDATA[gi]) begin
                    r_chg <= 1'b0;
                end
            end
        end
        assign w_in_sync[gi*DATA_W +: DATA_W] = r_sync2;
        assign w_chg[gi] = r_chg;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_det_en <= 1'b0;
            r_mask   <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_det_en <= 1'b1;
            if (w_wr && (w_addr == A_MASK)) begin
                r_mask <= PWDATA[N_IN-1:0];
            end
            r_irq <= |(w_chg & r_mask);
        end
    end

    assign CHG_IRQ = r_irq;

endmodule
